// File: rtl/fifo_byte_serializer.sv
// Drains FWFT FIFO words into an MSB-first byte stream; first byte follows the pop by one cycle, back-to-back words run without bubbles.
// Output bytes hold while tx_ready is low; define SERIALIZER_FRAMING_EN to wrap each word as A5 + data + XOR checksum.
module fifo_byte_serializer #(
   parameter int DATA_WIDTH = 40
) (
   input  logic                  rdclk,
   input  logic                  rrst_n,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic [15:0]           words_sent
);

   localparam int NBYTES = DATA_WIDTH / 8;
`ifdef SERIALIZER_FRAMING_EN
   localparam int FRAME_LEN = NBYTES + 2;
`else
   localparam int FRAME_LEN = NBYTES;
`endif
   localparam int IDX_W = $clog2(NBYTES + 2);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [15:0]           words_q, words_d;
   logic                  accept;
   logic                  last_acc;
   logic                  load;
   logic                  data_acc;
   logic [7:0]            cur_byte;

`ifdef SERIALIZER_FRAMING_EN
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   logic [7:0] csum_q, csum_d;
   logic       is_sync;
   logic       is_csum;
`endif

   always_comb begin
      accept   = (state_q == ST_SEND) && tx_ready;
      last_acc = accept && (idx_q == LAST_IDX);
      // rrst_n gates the pop so an asserted reset can never consume a word
      load     = !fifo_empty && rrst_n && ((state_q == ST_IDLE) || last_acc);
`ifdef SERIALIZER_FRAMING_EN
      is_sync  = (idx_q == '0);
      is_csum  = (idx_q == LAST_IDX);
      cur_byte = is_sync ? SYNC_BYTE :
                 is_csum ? csum_q    : shreg_q[DATA_WIDTH-1 -: 8];
      data_acc = accept && !is_sync && !is_csum;
`else
      cur_byte = shreg_q[DATA_WIDTH-1 -: 8];
      data_acc = accept;
`endif
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      words_d = words_q;
`ifdef SERIALIZER_FRAMING_EN
      csum_d  = csum_q;
`endif
      if (data_acc) begin
         shreg_d = shreg_q << 8;
      end
      if (accept) begin
         idx_d = idx_q + IDX_W'(1);
      end
      if (last_acc) begin
         words_d = words_q + 16'd1;
         state_d = ST_IDLE;
      end
      // A load in the same cycle as the last acceptance overrides the return to idle
      if (load) begin
         shreg_d = fifo_dout;
         idx_d   = '0;
         state_d = ST_SEND;
`ifdef SERIALIZER_FRAMING_EN
         csum_d  = 8'h00;
         for (int b = 0; b < NBYTES; b++) begin
            csum_d = csum_d ^ fifo_dout[b*8 +: 8];
         end
`endif
      end
   end

   always_ff @(posedge rdclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         words_q <= '0;
`ifdef SERIALIZER_FRAMING_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         words_q <= words_d;
`ifdef SERIALIZER_FRAMING_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign fifo_rd_en = load;
   assign tx_valid   = (state_q == ST_SEND);
   assign tx_data    = (state_q == ST_SEND) ? cur_byte : 8'h00;
   assign busy       = (state_q == ST_SEND);
   assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboard bench for fifo_byte_serializer: FIFO model, random backpressure, directed timing and reset cases.
`timescale 1ns/1ps
module tb_fifo_byte_serializer;
   localparam int DW = 40;
   localparam int NB = DW / 8;
`ifdef SERIALIZER_FRAMING_EN
   localparam int FL = NB + 2;
   localparam bit FRAMING = 1'b1;
`else
   localparam int FL = NB;
   localparam bit FRAMING = 1'b0;
`endif

   logic          rdclk = 1'b0;
   logic          rrst_n = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic          busy;
   logic [15:0]   words_sent;

   always #5 rdclk = ~rdclk;

   fifo_byte_serializer #(.DATA_WIDTH(DW)) dut (
      .rdclk      (rdclk),
      .rrst_n     (rrst_n),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .words_sent (words_sent)
   );

   logic [DW-1:0] fq[$];
   logic [DW-1:0] pend[$];
   logic [7:0]    exp_q[$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            ready_mode = 1;
   bit            pop_flag = 1'b0;
   int            in_frame = 0;
   int            exp_words = 0;
   int            pops = 0;
   int            pushes = 0;
   bit            prev_stall = 1'b0;
   logic [7:0]    prev_data = 8'h00;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, expv);
   endtask

   // Expected frame comes straight from the word: optional sync, bytes MSB first, optional XOR
   task automatic push_word(input logic [DW-1:0] w);
      logic [7:0] cs;
      cs = 8'h00;
      pend.push_back(w);
      pushes++;
      if (FRAMING) exp_q.push_back(8'hA5);
      for (int i = NB - 1; i >= 0; i--) begin
         exp_q.push_back(w[i*8 +: 8]);
         cs = cs ^ w[i*8 +: 8];
      end
      if (FRAMING) exp_q.push_back(cs);
   endtask

   task automatic wait_idle(input int limit);
      int  n;
      bit  timed_out;
      n = 0;
      timed_out = 1'b0;
      while (exp_q.size() != 0 || fq.size() != 0 || pend.size() != 0 || busy) begin
         @(negedge rdclk);
         n++;
         if (n > limit) begin
            timed_out = 1'b1;
            break;
         end
      end
      chk("drain_timeout", {31'd0, timed_out}, 32'd0);
   endtask

   // FIFO model and tx_ready driver, updated just after each rising edge
   always @(posedge rdclk) begin
      #1;
      if (pop_flag && fq.size() > 0) void'(fq.pop_front());
      while (pend.size() > 0) fq.push_back(pend.pop_front());
      fifo_empty = (fq.size() == 0);
      fifo_dout  = fifo_empty ? '0 : fq[0];
      case (ready_mode)
         0:       tx_ready = 1'b0;
         1:       tx_ready = 1'b1;
         default: tx_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Monitor: samples between edges, pops the scoreboard on every accepted byte
   always @(negedge rdclk) begin
      pop_flag = 1'b0;
      if (!rrst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (fifo_rd_en) begin
            pops++;
            pop_flag = 1'b1;
            chk("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
         end
         chk("busy_vs_valid", {31'd0, busy}, {31'd0, tx_valid});
         chk("words_sent", {16'd0, words_sent}, {16'd0, exp_words[15:0]});
         if (prev_stall) begin
            chk("stall_valid", {31'd0, tx_valid}, 32'd1);
            chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_byte: got %02h with empty scoreboard", tx_data);
            end else begin
               chk("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            in_frame++;
            if (in_frame == FL) begin
               in_frame = 0;
               exp_words++;
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   bit rd_log[64];
   bit v_log[64];
   int busy_cnt;
   int wcnt;

   initial begin
      // Reset: a queued word must not be popped while reset is held
      push_word(40'h0123456789);
      repeat (3) @(negedge rdclk);
      chk("rst_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_words_sent", {16'd0, words_sent}, 32'd0);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      @(posedge rdclk); #3;
      rrst_n = 1'b1;
      wait_idle(200);

      // Single word latency and spacing with tx_ready held high
      @(negedge rdclk);
      push_word(40'h0123456789);
      busy_cnt = 0;
      for (int c = 0; c < FL + 4; c++) begin
         @(negedge rdclk);
         rd_log[c] = fifo_rd_en;
         v_log[c]  = tx_valid;
         if (busy) busy_cnt++;
      end
      for (int c = 0; c < FL + 4; c++) begin
         chk("single_rd_en", {31'd0, rd_log[c]}, {31'd0, c == 0});
         chk("single_valid", {31'd0, v_log[c]}, {31'd0, (c >= 1) && (c <= FL)});
      end
      chk("single_busy_cycles", busy_cnt, FL);
      wait_idle(200);

      // Back-to-back: second pop coincides with the last byte of the first word
      @(negedge rdclk);
      push_word(40'h0123456789);
      push_word(40'hAABBCCDDEE);
      for (int c = 0; c < 2 * FL + 4; c++) begin
         @(negedge rdclk);
         rd_log[c] = fifo_rd_en;
         v_log[c]  = tx_valid;
      end
      for (int c = 0; c < 2 * FL + 4; c++) begin
         chk("b2b_rd_en", {31'd0, rd_log[c]}, {31'd0, (c == 0) || (c == FL)});
         chk("b2b_valid", {31'd0, v_log[c]}, {31'd0, (c >= 1) && (c <= 2 * FL)});
      end
      wait_idle(200);

      // Empty FIFO for 20 cycles under random ready
      ready_mode = 2;
      wcnt = exp_words;
      for (int c = 0; c < 20; c++) begin
         @(negedge rdclk);
         chk("empty_rd_en", {31'd0, fifo_rd_en}, 32'd0);
         chk("empty_valid", {31'd0, tx_valid}, 32'd0);
      end
      chk("empty_words", {16'd0, words_sent}, {16'd0, wcnt[15:0]});

      // Reset mid-word after exactly two accepted bytes
      ready_mode = 0;
      @(negedge rdclk);
      push_word(40'h0123456789);
      for (int c = 0; c < 20 && !tx_valid; c++) @(negedge rdclk);
      chk("midrst_started", {31'd0, tx_valid}, 32'd1);
      ready_mode = 1;
      @(negedge rdclk);
      @(negedge rdclk);
      ready_mode = 0;
      @(posedge rdclk); #3;
      rrst_n = 1'b0;
      #1;
      chk("midrst_accepted", in_frame, 2);
      chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_words", {16'd0, words_sent}, 32'd0);
      chk("midrst_data", {24'd0, tx_data}, 32'd0);
      for (int i = in_frame; i < FL; i++) void'(exp_q.pop_front());
      in_frame  = 0;
      exp_words = 0;
      @(negedge rdclk);
      push_word(40'hAABBCCDDEE);
      repeat (2) @(negedge rdclk);
      chk("midrst_no_pop", {31'd0, fifo_rd_en}, 32'd0);
      @(posedge rdclk); #3;
      rrst_n = 1'b1;
      ready_mode = 1;
      wait_idle(200);

      // Random words, random gaps, random backpressure
      ready_mode = 2;
      for (int k = 0; k < 60; k++) begin
         @(negedge rdclk);
         push_word(DW'({$urandom(), $urandom()}));
         repeat ($urandom_range(0, 2 * FL)) @(negedge rdclk);
      end
      wait_idle(4000);
      chk("pop_count", pops, pushes);
      chk("scoreboard_residual", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
